bitwise_alu_checker: RTL

//  Self-checking response monitor for the Int_ALU bitwise logic gates (and/or/xor/not).

---
 rtl/bitwise_alu_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bitwise_alu_checker.sv
// rtl/bitwise_alu_checker.sv - response monitor that checks and/or/xor/not gate outputs
module bitwise_alu_checker #(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 16,
  parameter int NUM_VECTORS  = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_o,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [1:0]       fail_op,
  output logic [WIDTH-1:0] fail_x,
  output logic [WIDTH-1:0] fail_y,
  output logic [WIDTH-1:0] fail_o,
  output logic [WIDTH-1:0] fail_exp
);

  // Accept counter only needs to reach NUM_VECTORS; unbounded runs keep a dummy bit.
  localparam int ACC_W = (NUM_VECTORS > 0) ? $clog2(NUM_VECTORS + 1) : 1;
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_VECTORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             stg_valid;
  logic [1:0]       stg_op;
  logic [WIDTH-1:0] stg_x;
  logic [WIDTH-1:0] stg_y;
  logic [WIDTH-1:0] stg_o;
  logic [ACC_W-1:0] acc_cnt;
  logic [WIDTH-1:0] exp_val;

  logic room;
  logic accept;
  logic last_accept;
  logic mismatch;
  logic halt_now;
  logic start_run;

  // Reference result of the vector sitting in the stage register.
  always_comb begin
    exp_val = '0;
    case (stg_op)
      2'b00:   exp_val = stg_x & stg_y;
      2'b01:   exp_val = stg_x | stg_y;
      2'b10:   exp_val = stg_x ^ stg_y;
      default: exp_val = ~stg_x;
    endcase
  end

  assign room        = (NUM_VECTORS == 0) || (acc_cnt < ACC_LAST);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (NUM_VECTORS != 0) && (acc_cnt == ACC_LAST - ACC_W'(1));
  assign mismatch    = stg_valid && (stg_o != exp_val);
  assign halt_now    = (STOP_ON_FAIL != 0) && mismatch;
  assign start_run   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_HALT));
  assign error       = (fail_cnt != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; the stage always empties in the DRAIN cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_HALT: begin
        done = (state != S_IDLE);
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = room;
        if (halt_now)         state_nxt = S_HALT;
        else if (last_accept) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (halt_now) state_nxt = S_HALT;
        else          state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage register, saturating counters and first-fail capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg_op    <= '0;
      stg_x     <= '0;
      stg_y     <= '0;
      stg_o     <= '0;
      acc_cnt   <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_op   <= '0;
      fail_x    <= '0;
      fail_y    <= '0;
      fail_o    <= '0;
      fail_exp  <= '0;
    end else if (start_run) begin
      stg_valid <= 1'b0;
      acc_cnt   <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_op   <= '0;
      fail_x    <= '0;
      fail_y    <= '0;
      fail_o    <= '0;
      fail_exp  <= '0;
    end else begin
      if (mismatch) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (fail_cnt == '0) begin
          fail_op  <= stg_op;
          fail_x   <= stg_x;
          fail_y   <= stg_y;
          fail_o   <= stg_o;
          fail_exp <= exp_val;
        end
      end else if (stg_valid) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end
      // A vector arriving on the edge that halts the run is dropped uncounted.
      if (accept && !halt_now) begin
        stg_valid <= 1'b1;
        stg_op    <= in_op;
        stg_x     <= in_x;
        stg_y     <= in_y;
        stg_o     <= in_o;
        if (NUM_VECTORS != 0) acc_cnt <= acc_cnt + ACC_W'(1);
      end else begin
        stg_valid <= 1'b0;
      end
    end
  end

endmodule
